// File: rtl/decode_pkg.sv
// Shared decode definitions: instruction field offsets and the D/E pipeline record.
// The record is sized for the widest supported configuration; narrower builds zero-extend.
package decode_pkg;

  localparam int unsigned PMax = 32;
  localparam int unsigned DMax = 64;
  localparam int unsigned FMax = 8;
  localparam int unsigned RMax = 8;

  typedef struct packed {
    logic            valid;
    logic [PMax-1:0] next_pc;
    logic [FMax-1:0] funct;
    logic [RMax-1:0] rd;
    logic [DMax-1:0] rs;
    logic [DMax-1:0] rt;
  } de_rec_t;

  function automatic int unsigned ra1_lsb(input int unsigned f);
    return f;
  endfunction

  function automatic int unsigned ra2_lsb(input int unsigned f, input int unsigned r);
    return f + r;
  endfunction

  function automatic int unsigned rd_lsb(input int unsigned f, input int unsigned r);
    return f + 2 * r;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 2**R x D register file, two combinational read ports with write bypass, one write port.
module regfile_2r1w
  import decode_pkg::*;
#(
  parameter int unsigned D        = 16,
  parameter int unsigned R        = 4,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [R-1:0] ra1_i,
  input  logic [R-1:0] ra2_i,
  output logic [D-1:0] rd1_o,
  output logic [D-1:0] rd2_o,
  input  logic         we_i,
  input  logic [R-1:0] wa_i,
  input  logic [D-1:0] wd_i
);

  localparam int unsigned N = 2 ** R;

  logic [D-1:0] r_mem [N];
  logic         w_wr_en;

  assign w_wr_en = we_i && !((ZERO_REG != 0) && (wa_i == '0));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < N; k++) begin
        r_mem[k] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[wa_i] <= wd_i;
    end
  end

  // Zero-register forcing is applied last so it also overrides the bypass.
  always_comb begin
    rd1_o = r_mem[ra1_i];
    if (we_i && (wa_i == ra1_i)) rd1_o = wd_i;
    if ((ZERO_REG != 0) && (ra1_i == '0)) rd1_o = '0;
  end

  always_comb begin
    rd2_o = r_mem[ra2_i];
    if (we_i && (wa_i == ra2_i)) rd2_o = wd_i;
    if ((ZERO_REG != 0) && (ra2_i == '0)) rd2_o = '0;
  end

endmodule

// File: rtl/decode_pipe_stage.sv
// Decode stage: slices instruction fields, reads operands and holds the D/E pipeline register
// with flush-over-stall priority.
module decode_pipe_stage
  import decode_pkg::*;
#(
  parameter int unsigned I        = 16,
  parameter int unsigned P        = 16,
  parameter int unsigned D        = 16,
  parameter int unsigned R        = 4,
  parameter int unsigned F        = 4,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  logic [I-1:0] instr_i,
  input  logic [P-1:0] next_pc_i,
  input  logic         stall_i,
  input  logic         flush_i,
  input  logic         we3,
  input  logic [R-1:0] wa3,
  input  logic [D-1:0] wd3,
  output logic         ready_o,
  output logic         valid_o,
  output logic [P-1:0] next_pc_o,
  output logic [F-1:0] funct_o,
  output logic [R-1:0] rd_o,
  output logic [D-1:0] rs_o,
  output logic [D-1:0] rt_o
);

  localparam int unsigned Ra1Lsb = ra1_lsb(F);
  localparam int unsigned Ra2Lsb = ra2_lsb(F, R);
  localparam int unsigned RdLsb  = rd_lsb(F, R);

  if (I < F + 3 * R) begin : g_bad_instr_width
    $error("decode_pipe_stage: instruction width I too small for F+3R");
  end
  if ((P > PMax) || (D > DMax) || (F > FMax) || (R > RMax)) begin : g_bad_rec_width
    $error("decode_pipe_stage: parameter exceeds decode_pkg record width");
  end

  logic [R-1:0] w_ra1;
  logic [R-1:0] w_ra2;
  logic [D-1:0] w_rd1;
  logic [D-1:0] w_rd2;
  de_rec_t      w_de_d;
  de_rec_t      r_de;
  logic         w_unused_de;

  assign w_ra1 = instr_i[Ra1Lsb +: R];
  assign w_ra2 = instr_i[Ra2Lsb +: R];

  regfile_2r1w #(
    .D        (D),
    .R        (R),
    .ZERO_REG (ZERO_REG)
  ) u_regfile (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .ra1_i (w_ra1),
    .ra2_i (w_ra2),
    .rd1_o (w_rd1),
    .rd2_o (w_rd2),
    .we_i  (we3),
    .wa_i  (wa3),
    .wd_i  (wd3)
  );

  always_comb begin
    w_de_d = '0;
    if (flush_i) begin
      w_de_d = '0;
    end else if (stall_i) begin
      w_de_d = r_de;
    end else if (valid_i) begin
      w_de_d.valid          = 1'b1;
      w_de_d.next_pc[P-1:0] = next_pc_i;
      w_de_d.funct[F-1:0]   = instr_i[F-1:0];
      w_de_d.rd[R-1:0]      = instr_i[RdLsb +: R];
      w_de_d.rs[D-1:0]      = w_rd1;
      w_de_d.rt[D-1:0]      = w_rd2;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_de <= '0;
    end else begin
      r_de <= w_de_d;
    end
  end

  assign ready_o   = !stall_i;
  assign valid_o   = r_de.valid;
  assign next_pc_o = r_de.next_pc[P-1:0];
  assign funct_o   = r_de.funct[F-1:0];
  assign rd_o      = r_de.rd[R-1:0];
  assign rs_o      = r_de.rs[D-1:0];
  assign rt_o      = r_de.rt[D-1:0];

  // Upper record bits beyond the configured widths stay zero and are never observed.
  assign w_unused_de = ^r_de;

endmodule
